// File: rtl/approx_err_monitor.sv
// approx_err_monitor
// Error-metric collector for approximate adders. Accepts (exact, approximate)
// result pairs over a valid/ready handshake for a programmed number of samples.
// It accumulates four figures in integer hardware: the error count, the
// acceptance count, the signed error sum and the absolute error sum. The host
// derives ER / OE / AP / mean accuracy from these counters.
//
// Optional feature: define ERR_MAX_TRACK_EN to add max_abs_err / max_idx,
// which report the largest |exp-act| seen and the index of its first occurrence.
//
// Pipeline: stage 1 registers the per-sample metrics on the handshake edge.
// Stage 2 folds them into the accumulators on the following edge. DRAIN covers
// both stages, so the results are final before done rises.

module approx_err_monitor #(
    parameter int W       = 16,
    parameter int CNT_W   = 32,
    parameter int REL_NUM = 1,
    parameter int REL_DEN = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       n_samples,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [W:0]             exp_val,
    input  logic [W:0]             act_val,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       acc_cnt,
    output logic [CNT_W+W:0]       sum_abs_err,
    output logic [CNT_W+W+1:0]     sum_sgn_err
`ifdef ERR_MAX_TRACK_EN
    ,
    output logic [W:0]             max_abs_err,
    output logic [CNT_W-1:0]       max_idx
`endif
);

    localparam int AW = CNT_W + W + 1;   // absolute-sum width
    localparam int SW = CNT_W + W + 2;   // signed-sum width
    localparam int DW = W + 2;           // signed difference width
    localparam int PW = W + 1 + 32;      // threshold product width (no truncation)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Saturating arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    function automatic logic [AW-1:0] abs_acc(input logic [AW-1:0] acc,
                                              input logic [W:0]    inc);
        logic [AW:0] t;
        t = {1'b0, acc} + {{(AW-W){1'b0}}, inc};
        if (t[AW]) begin
            return {AW{1'b1}};
        end else begin
            return t[AW-1:0];
        end
    endfunction

    function automatic logic [SW-1:0] sgn_acc(input logic [SW-1:0] acc,
                                              input logic [DW-1:0] inc);
        logic [SW:0] t;
        t = {acc[SW-1], acc} + {{(SW+1-DW){inc[DW-1]}}, inc};
        if (t[SW] != t[SW-1]) begin
            if (t[SW]) begin
                return {1'b1, {(SW-1){1'b0}}};   // most negative
            end else begin
                return {1'b0, {(SW-1){1'b1}}};   // most positive
            end
        end else begin
            return t[SW-1:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t             state_r;
    logic [CNT_W-1:0]   n_lat_r;
    logic [CNT_W-1:0]   sample_cnt_r;
    logic               s_ready_r;
    logic               busy_r;
    logic               done_r;
    logic               drain_r;

    logic               v1_r;
    logic [DW-1:0]      diff1_r;
    logic [W:0]         abs1_r;
    logic               neq1_r;
    logic               acc1_r;

    logic [CNT_W-1:0]   err_cnt_r;
    logic [CNT_W-1:0]   acc_cnt_r;
    logic [AW-1:0]      sum_abs_r;
    logic [SW-1:0]      sum_sgn_r;

`ifdef ERR_MAX_TRACK_EN
    logic [CNT_W-1:0]   idx1_r;
    logic [W:0]         max_abs_r;
    logic [CNT_W-1:0]   max_idx_r;
`endif

    // ------------------------------------------------------------------
    // Combinational per-sample metrics
    // ------------------------------------------------------------------
    logic               hs_s;
    logic               start_take_s;
    logic               last_s;
    logic [DW-1:0]      diff_s;
    logic [W:0]         abs_s;
    logic [PW-1:0]      lhs_s;
    logic [PW-1:0]      rhs_s;
    logic               accept_s;
    logic               neq_s;

    assign hs_s         = s_valid & s_ready_r;
    assign start_take_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign last_s       = (({1'b0, sample_cnt_r} + (CNT_W+1)'(1)) >= {1'b0, n_lat_r});
    assign diff_s       = {1'b0, exp_val} - {1'b0, act_val};
    assign neq_s        = (exp_val != act_val);

    // Magnitude of the difference, computed directly in W+1 bits
    always_comb begin
        abs_s = {(W+1){1'b0}};
        if (exp_val >= act_val) begin
            abs_s = exp_val - act_val;
        end else begin
            abs_s = act_val - exp_val;
        end
    end

    // Acceptance test: |diff|/exp < REL_NUM/REL_DEN, cross-multiplied at full width
    always_comb begin
        lhs_s    = PW'(abs_s) * PW'(REL_DEN);
        rhs_s    = PW'(exp_val) * PW'(REL_NUM);
        accept_s = 1'b0;
        if (exp_val == {(W+1){1'b0}}) begin
            accept_s = (diff_s == {DW{1'b0}});
        end else begin
            accept_s = (lhs_s < rhs_s);
        end
    end

    // ------------------------------------------------------------------
    // Campaign control FSM with registered handshake/status outputs
    // ------------------------------------------------------------------
    // Sequences IDLE/DONE -> RUN -> DRAIN (2 cycles) -> DONE and counts handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            n_lat_r      <= {CNT_W{1'b0}};
            sample_cnt_r <= {CNT_W{1'b0}};
            s_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            drain_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r      <= ST_RUN;
                        n_lat_r      <= n_samples;
                        sample_cnt_r <= {CNT_W{1'b0}};
                        s_ready_r    <= (n_samples != {CNT_W{1'b0}});
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        drain_r      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (hs_s) begin
                        sample_cnt_r <= cnt_inc(sample_cnt_r);
                        if (last_s) begin
                            state_r   <= ST_DRAIN;
                            s_ready_r <= 1'b0;
                            drain_r   <= 1'b0;
                        end
                    end else if (sample_cnt_r >= n_lat_r) begin
                        // zero-length campaign: nothing to collect
                        state_r   <= ST_DRAIN;
                        s_ready_r <= 1'b0;
                        drain_r   <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_r) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        drain_r <= 1'b0;
                    end else begin
                        drain_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    s_ready_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    drain_r   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture per-sample metrics on the handshake edge
    // ------------------------------------------------------------------
    // Registers diff, |diff|, mismatch and acceptance flags for accepted pairs only
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r    <= 1'b0;
            diff1_r <= {DW{1'b0}};
            abs1_r  <= {(W+1){1'b0}};
            neq1_r  <= 1'b0;
            acc1_r  <= 1'b0;
        end else if (start_take_s) begin
            v1_r    <= 1'b0;
            diff1_r <= {DW{1'b0}};
            abs1_r  <= {(W+1){1'b0}};
            neq1_r  <= 1'b0;
            acc1_r  <= 1'b0;
        end else begin
            v1_r <= hs_s;
            if (hs_s) begin
                diff1_r <= diff_s;
                abs1_r  <= abs_s;
                neq1_r  <= neq_s;
                acc1_r  <= accept_s;
            end
        end
    end

`ifdef ERR_MAX_TRACK_EN
    // Remembers the index of the sample held in stage 1 (count before increment)
    always_ff @(posedge clk) begin
        if (rst) begin
            idx1_r <= {CNT_W{1'b0}};
        end else if (start_take_s) begin
            idx1_r <= {CNT_W{1'b0}};
        end else if (hs_s) begin
            idx1_r <= sample_cnt_r;
        end
    end
`else
    // Extreme-value tracking is not built in this configuration.
`endif

    // ------------------------------------------------------------------
    // Stage 2: saturating accumulation; bubbles add nothing
    // ------------------------------------------------------------------
    // Folds stage-1 metrics into the campaign accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= {CNT_W{1'b0}};
            acc_cnt_r <= {CNT_W{1'b0}};
            sum_abs_r <= {AW{1'b0}};
            sum_sgn_r <= {SW{1'b0}};
        end else if (start_take_s) begin
            err_cnt_r <= {CNT_W{1'b0}};
            acc_cnt_r <= {CNT_W{1'b0}};
            sum_abs_r <= {AW{1'b0}};
            sum_sgn_r <= {SW{1'b0}};
        end else if (v1_r) begin
            if (neq1_r) begin
                err_cnt_r <= cnt_inc(err_cnt_r);
            end
            if (acc1_r) begin
                acc_cnt_r <= cnt_inc(acc_cnt_r);
            end
            sum_abs_r <= abs_acc(sum_abs_r, abs1_r);
            sum_sgn_r <= sgn_acc(sum_sgn_r, diff1_r);
        end
    end

`ifdef ERR_MAX_TRACK_EN
    // Tracks the largest |diff|; strict compare keeps the earliest on ties
    always_ff @(posedge clk) begin
        if (rst) begin
            max_abs_r <= {(W+1){1'b0}};
            max_idx_r <= {CNT_W{1'b0}};
        end else if (start_take_s) begin
            max_abs_r <= {(W+1){1'b0}};
            max_idx_r <= {CNT_W{1'b0}};
        end else if (v1_r && (abs1_r > max_abs_r)) begin
            max_abs_r <= abs1_r;
            max_idx_r <= idx1_r;
        end
    end

    assign max_abs_err = max_abs_r;
    assign max_idx     = max_idx_r;
`endif

    assign s_ready     = s_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign sample_cnt  = sample_cnt_r;
    assign err_cnt     = err_cnt_r;
    assign acc_cnt     = acc_cnt_r;
    assign sum_abs_err = sum_abs_r;
    assign sum_sgn_err = sum_sgn_r;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Testbench for approx_err_monitor: table-driven campaigns plus hand-written
// sequences for zero-length runs, handshake gaps/overrun and mid-run reset.

module tb_approx_err_monitor;

    localparam int W     = 16;
    localparam int CNT_W = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [CNT_W-1:0]       n_samples;
    logic                   s_valid;
    logic                   s_ready;
    logic [W:0]             exp_val;
    logic [W:0]             act_val;
    logic                   busy;
    logic                   done;
    logic [CNT_W-1:0]       sample_cnt;
    logic [CNT_W-1:0]       err_cnt;
    logic [CNT_W-1:0]       acc_cnt;
    logic [CNT_W+W:0]       sum_abs_err;
    logic [CNT_W+W+1:0]     sum_sgn_err;
`ifdef ERR_MAX_TRACK_EN
    logic [W:0]             max_abs_err;
    logic [CNT_W-1:0]       max_idx;
`endif

    approx_err_monitor #(.W(W), .CNT_W(CNT_W), .REL_NUM(1), .REL_DEN(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .n_samples   (n_samples),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .exp_val     (exp_val),
        .act_val     (act_val),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .acc_cnt     (acc_cnt),
        .sum_abs_err (sum_abs_err),
        .sum_sgn_err (sum_sgn_err)
`ifdef ERR_MAX_TRACK_EN
        ,
        .max_abs_err (max_abs_err),
        .max_idx     (max_idx)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0]         n;
        logic [3:0][16:0]    e;
        logic [3:0][16:0]    a;
        logic [31:0]         x_smp;
        logic [31:0]         x_err;
        logic [31:0]         x_acc;
        logic [63:0]         x_abs;
        logic signed [63:0]  x_sgn;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint got, input longint expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int n,
                                input int e0, input int a0, input int e1, input int a1,
                                input int e2, input int a2, input int e3, input int a3,
                                input int smp, input int err, input int acc,
                                input longint sabs, input longint ssgn);
        vec_t v;
        v.n = 32'(n);
        v.e[0] = 17'(e0); v.a[0] = 17'(a0);
        v.e[1] = 17'(e1); v.a[1] = 17'(a1);
        v.e[2] = 17'(e2); v.a[2] = 17'(a2);
        v.e[3] = 17'(e3); v.a[3] = 17'(a3);
        v.x_smp = 32'(smp);
        v.x_err = 32'(err);
        v.x_acc = 32'(acc);
        v.x_abs = 64'(sabs);
        v.x_sgn = ssgn;
        return v;
    endfunction

    task automatic do_start(input logic [31:0] n);
        start     = 1'b1;
        n_samples = n;
        step();
        start     = 1'b0;
    endtask

    // waits for done with a cycle bound; k = edges counted
    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 20) begin
            step();
            k++;
        end
    endtask

    task automatic check_results(input string tag, input vec_t v);
        chk({tag, "_sample_cnt"}, longint'(sample_cnt), longint'(v.x_smp));
        chk({tag, "_err_cnt"},    longint'(err_cnt),    longint'(v.x_err));
        chk({tag, "_acc_cnt"},    longint'(acc_cnt),    longint'(v.x_acc));
        chk({tag, "_sum_abs"},    longint'(sum_abs_err), longint'(v.x_abs));
        chk({tag, "_sum_sgn"},    longint'($signed(sum_sgn_err)), longint'(v.x_sgn));
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   idx;
        int   budget;
        int   k;
        logic hs;
        string tag;
        v      = vecs[i];
        tag    = $sformatf("v%0d", i);
        idx    = 0;
        budget = 0;
        s_valid = 1'b0;
        do_start(v.n);
        while (idx < int'(v.n) && budget < 50) begin
            s_valid = 1'b1;
            exp_val = v.e[idx];
            act_val = v.a[idx];
            hs      = s_ready;
            step();
            if (hs) idx++;
            budget++;
        end
        s_valid = 1'b0;
        chk({tag, "_handshakes"}, longint'(idx), longint'(v.n));
        wait_done(k);
        chk({tag, "_done"}, longint'(done), 64'sd1);
        chk({tag, "_done_latency"}, longint'(k), (v.n == 32'd0) ? 64'sd3 : 64'sd2);
        chk({tag, "_busy_low"}, longint'(busy), 64'sd0);
        check_results(tag, v);
`ifdef ERR_MAX_TRACK_EN
        if (i == 4) begin
            chk({tag, "_max_abs"}, longint'(max_abs_err), 64'sd101);
            chk({tag, "_max_idx"}, longint'(max_idx), 64'sd1);
        end
`endif
    endtask

    initial begin
        int   hs_cnt;
        int   c;
        int   k;
        logic hs;

        //           n  e0      a0      e1    a1      e2   a2   e3      a3      smp err acc abs     sgn
        vecs[0] = mk(4, 10,     10,     200,  200,    0,   0,   131071, 131071, 4,  0,  4,  0,      0);
        vecs[1] = mk(1, 100,    95,     0,    0,      0,   0,   0,      0,      1,  1,  1,  5,      5);
        vecs[2] = mk(1, 100,    110,    0,    0,      0,   0,   0,      0,      1,  1,  0,  10,     -10);
        vecs[3] = mk(2, 0,      0,      0,    1,      0,   0,   0,      0,      2,  1,  1,  1,      -1);
        vecs[4] = mk(3, 1000,   1099,   1000, 1101,   50,  40,  0,      0,      3,  3,  1,  210,    -190);
        vecs[5] = mk(2, 131071, 0,      0,    131071, 0,   0,   0,      0,      2,  2,  0,  262142, 0);
        vecs[6] = mk(0, 0,      0,      0,    0,      0,   0,   0,      0,      0,  0,  0,  0,      0);

        rst       = 1'b1;
        start     = 1'b0;
        n_samples = 32'd0;
        s_valid   = 1'b0;
        exp_val   = 17'd0;
        act_val   = 17'd0;
        repeat (3) step();

        // reset state
        chk("rst_s_ready", longint'(s_ready), 64'sd0);
        chk("rst_busy",    longint'(busy),    64'sd0);
        chk("rst_done",    longint'(done),    64'sd0);
        chk("rst_sample",  longint'(sample_cnt), 64'sd0);
        chk("rst_sum_abs", longint'(sum_abs_err), 64'sd0);
        rst = 1'b0;
        step();
        chk("idle_busy", longint'(busy), 64'sd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // n=3 with gaps in s_valid, start pulsed mid-run, 4th pair offered
        do_start(32'd3);
        chk("gap_busy", longint'(busy), 64'sd1);
        hs_cnt = 0;
        c      = 0;
        while (hs_cnt < 3 && c < 30) begin
            s_valid   = ((c % 2) == 0) || (c >= 3);
            start     = (c == 1);
            n_samples = 32'd1;
            exp_val   = 17'd5;
            act_val   = 17'd5;
            hs        = s_ready && s_valid;
            step();
            if (hs) hs_cnt++;
            c++;
        end
        start   = 1'b0;
        chk("gap_handshakes", longint'(hs_cnt), 64'sd3);
        s_valid = 1'b1;
        exp_val = 17'd7;
        act_val = 17'd0;
        chk("gap_ready_low", longint'(s_ready), 64'sd0);
        wait_done(k);
        chk("gap_done_latency", longint'(k), 64'sd2);
        s_valid = 1'b0;
        step();
        chk("gap_sample_cnt", longint'(sample_cnt), 64'sd3);
        chk("gap_err_cnt",    longint'(err_cnt),    64'sd0);
        chk("gap_acc_cnt",    longint'(acc_cnt),    64'sd3);
        chk("gap_sum_abs",    longint'(sum_abs_err), 64'sd0);
        chk("gap_done_hold",  longint'(done),       64'sd1);

        // reset in the middle of a campaign
        do_start(32'd5);
        hs_cnt = 0;
        c      = 0;
        while (hs_cnt < 2 && c < 20) begin
            s_valid = 1'b1;
            exp_val = 17'd100;
            act_val = 17'd90;
            hs      = s_ready;
            step();
            if (hs) hs_cnt++;
            c++;
        end
        s_valid = 1'b0;
        step();
        chk("mid_sample_cnt", longint'(sample_cnt), 64'sd2);
        chk("mid_err_cnt",    longint'(err_cnt),    64'sd2);
        chk("mid_busy",       longint'(busy),       64'sd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy",    longint'(busy),       64'sd0);
        chk("mrst_done",    longint'(done),       64'sd0);
        chk("mrst_s_ready", longint'(s_ready),    64'sd0);
        chk("mrst_sample",  longint'(sample_cnt), 64'sd0);
        chk("mrst_err",     longint'(err_cnt),    64'sd0);
        chk("mrst_sum_abs", longint'(sum_abs_err), 64'sd0);
        chk("mrst_sum_sgn", longint'($signed(sum_sgn_err)), 64'sd0);
        step();
        chk("mrst_idle_busy", longint'(busy), 64'sd0);

        // clean restart after reset
        run_vec(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
